capture_ctrl: RTL and testbench

- Acquisition front end that writes ADC samples into port A of the sample-buffer dual-port RAM.
- Fills a circular pre-trigger window, then arms and detects a level/edge trigger. Captures the post-trigger samples and stops.
- Reports the trigger address and the waveform start address for the display readout on port B.

---
 rtl/capture_ctrl.sv | 154 +++++++++++++++
 tb/tb_capture_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// Acquisition front end for the sample-buffer dual-port RAM (port A).
// Fills a circular pre-trigger window, arms, detects a level/edge trigger,
// captures the post-trigger samples and stops. It reports the trigger
// address and the waveform start address for the port-B display readout.
module capture_ctrl #(
  parameter int unsigned addr_width = 15,
  parameter int unsigned data_width = 12
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic                  force_trig,
  input  logic                  trig_rising,
  input  logic [data_width-1:0] trig_level,
  input  logic [addr_width-1:0] pretrig,
  input  logic                  sample_valid,
  input  logic [data_width-1:0] sample,
  output logic [addr_width-1:0] ram_addr,
  output logic                  ram_we,
  output logic [data_width-1:0] ram_din,
  output logic                  busy,
  output logic                  armed,
  output logic                  done,
  output logic [addr_width-1:0] trig_addr,
  output logic [addr_width-1:0] start_addr
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ARMED,
    POST,
    DONE
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [addr_width-1:0] wr_ptr;
  logic [addr_width-1:0] cnt;
  logic [addr_width-1:0] pre_q;
  logic [data_width-1:0] prev;
  logic                  prev_valid;

  logic                  capturing;
  logic                  accept;
  logic                  rise_hit;
  logic                  fall_hit;
  logic                  trig_hit;
  logic [addr_width-1:0] cnt_inc;
  logic [addr_width-1:0] cnt_dec;
  logic [addr_width-1:0] post_load;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode, sample acceptance, trigger detection and status flags
  always_comb begin
    state_next = state;
    capturing  = (state == FILL) || (state == ARMED) || (state == POST);
    // A sample arriving in the arm cycle is dropped; the capture restarts clean.
    accept     = sample_valid && !arm && capturing;
    rise_hit   = prev_valid && trig_rising &&
                 (prev < trig_level) && (trig_level <= sample);
    fall_hit   = prev_valid && !trig_rising &&
                 (prev > trig_level) && (trig_level >= sample);
    trig_hit   = (state == ARMED) && accept && (force_trig || rise_hit || fall_hit);
    cnt_inc    = cnt + addr_width'(1);
    cnt_dec    = cnt - addr_width'(1);
    // depth - pre - 1, computed modulo depth
    post_load  = '1 - pre_q;

    if (arm) begin
      state_next = (pretrig == '0) ? ARMED : FILL;
    end else begin
      case (state)
        FILL: begin
          if (accept && (cnt_inc == pre_q)) begin
            state_next = ARMED;
          end
        end
        ARMED: begin
          if (trig_hit) begin
            state_next = (post_load == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (accept && (cnt == addr_width'(1))) begin
            state_next = DONE;
          end
        end
        default: state_next = state;
      endcase
    end

    busy  = capturing;
    armed = (state == ARMED);
    done  = (state == DONE);
  end

  // Write path, pointers, counters and trigger bookkeeping
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_din    <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      pre_q      <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else begin
      ram_we <= accept;
      if (accept) begin
        ram_addr   <= wr_ptr;
        ram_din    <= sample;
        wr_ptr     <= wr_ptr + addr_width'(1);
        prev       <= sample;
        prev_valid <= 1'b1;
      end

      if (arm) begin
        // pretrig is addr_width bits wide, so it can never exceed depth-1
        // and the clamp to depth-1 is implicit.
        pre_q      <= pretrig;
        wr_ptr     <= '0;
        cnt        <= '0;
        prev_valid <= 1'b0;
      end else if (accept) begin
        case (state)
          FILL:  cnt <= cnt_inc;
          ARMED: begin
            if (trig_hit) begin
              trig_addr  <= wr_ptr;
              start_addr <= wr_ptr - pre_q;
              cnt        <= post_load;
            end
          end
          POST:  cnt <= cnt_dec;
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed testbench for capture_ctrl with a 16-entry buffer.
module tb_capture_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 12;

  logic          clock;
  logic          reset_n;
  logic          arm;
  logic          force_trig;
  logic          trig_rising;
  logic [DW-1:0] trig_level;
  logic [AW-1:0] pretrig;
  logic          sample_valid;
  logic [DW-1:0] sample;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic          busy;
  logic          armed;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;

  int unsigned   n_checks;
  int unsigned   n_fail;
  int            done_at;
  int unsigned   n_before;

  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];

  capture_ctrl #(
    .addr_width(AW),
    .data_width(DW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .arm         (arm),
    .force_trig  (force_trig),
    .trig_rising (trig_rising),
    .trig_level  (trig_level),
    .pretrig     (pretrig),
    .sample_valid(sample_valid),
    .sample      (sample),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_din     (ram_din),
    .busy        (busy),
    .armed       (armed),
    .done        (done),
    .trig_addr   (trig_addr),
    .start_addr  (start_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Log every RAM write, sampled mid-cycle
  always @(negedge clock) begin
    if (ram_we === 1'b1) begin
      wa.push_back(ram_addr);
      wd.push_back(ram_din);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_arm(input logic [AW-1:0] p);
    pretrig = p;
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic feed(input logic [DW-1:0] v);
    sample       = v;
    sample_valid = 1'b1;
    tick();
  endtask

  task automatic idle_tick;
    sample_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    arm          = 1'b0;
    force_trig   = 1'b0;
    trig_rising  = 1'b1;
    trig_level   = '0;
    pretrig      = '0;
    sample_valid = 1'b0;
    sample       = '0;
    tick();
    tick();

    // Reset state
    check("rst_addr",  32'(ram_addr),   32'd0);
    check("rst_we",    32'(ram_we),     32'd0);
    check("rst_din",   32'(ram_din),    32'd0);
    check("rst_flags", 32'({busy, armed, done}), 32'd0);
    check("rst_trig",  32'(trig_addr),  32'd0);
    check("rst_start", 32'(start_addr), 32'd0);
    reset_n = 1'b1;
    tick();

    // Rising trigger on a ramp, pre=4, level=10; arm-cycle sample 99 is dropped
    trig_rising  = 1'b1;
    trig_level   = 12'd10;
    force_trig   = 1'b0;
    sample_valid = 1'b1;
    sample       = 12'd99;
    pulse_arm(4'd4);
    check("t1_fill", 32'({busy, armed, done}), 32'b100);
    done_at = -1;
    for (int i = 0; i < 40; i++) begin
      feed(DW'(i));
      if (i == 2)  check("t1_fill_before_pre", 32'(armed), 32'd0);
      if (i == 3)  check("t1_armed_at_pre", 32'(armed), 32'd1);
      if (i == 9)  check("t1_no_trig_below", 32'(armed), 32'd1);
      if (i == 10) check("t1_post", 32'({busy, armed}), 32'b10);
      if (done) begin
        done_at = i;
        break;
      end
    end
    check("t1_done_at", 32'(done_at), 32'd21);
    check("t1_last_write", 32'({ram_we, ram_addr, ram_din}), 32'({1'b1, 4'd5, 12'd21}));
    check("t1_trig_addr", 32'(trig_addr), 32'd10);
    check("t1_start_addr", 32'(start_addr), 32'd6);
    feed(12'd30);
    feed(12'd31);
    idle_tick();
    check("t1_writes", 32'(wa.size()), 32'd22);
    check("t1_w0", 32'({wa[0], wd[0]}), 32'({4'd0, 12'd0}));
    check("t1_w3", 32'({wa[3], wd[3]}), 32'({4'd3, 12'd3}));
    check("t1_wtrig", 32'({wa[10], wd[10]}), 32'({4'd10, 12'd10}));
    check("t1_wlast", 32'({wa[21], wd[21]}), 32'({4'd5, 12'd21}));
    check("t1_done_hold", 32'({done, trig_addr, start_addr}), 32'({1'b1, 4'd10, 4'd6}));

    // Samples held at the level: no crossing, writes wrap forever
    pulse_arm(4'd4);
    for (int i = 0; i < 40; i++) feed(12'd10);
    check("t2_flags", 32'({busy, armed, done}), 32'b110);
    idle_tick();
    check("t2_writes", 32'(wa.size()), 32'd40);
    check("t2_w15", 32'(wa[15]), 32'd15);
    check("t2_wrap", 32'(wa[16]), 32'd0);
    check("t2_w39", 32'(wa[39]), 32'd7);

    // Falling trigger, level 5: 9,8,7,6,5 -> trigger on 5 (prev 6)
    trig_rising = 1'b0;
    trig_level  = 12'd5;
    pulse_arm(4'd4);
    for (int i = 0; i < 4; i++) feed(12'd20);
    check("t3_armed", 32'(armed), 32'd1);
    feed(12'd9);
    feed(12'd8);
    feed(12'd7);
    feed(12'd6);
    check("t3_no_trig_above", 32'(armed), 32'd1);
    feed(12'd5);
    check("t3_post", 32'({busy, armed}), 32'b10);
    check("t3_trig_addr", 32'(trig_addr), 32'd8);
    check("t3_start_addr", 32'(start_addr), 32'd4);

    // pre=0 with force: immediate ARMED, trigger at addr 0, 16 writes total
    trig_rising  = 1'b1;
    trig_level   = 12'd10;
    force_trig   = 1'b1;
    sample_valid = 1'b0;
    pulse_arm(4'd0);
    check("t4_armed_now", 32'({busy, armed, done}), 32'b110);
    feed(12'h7FF);
    check("t4_trig", 32'({busy, armed, trig_addr, start_addr}), 32'({2'b10, 4'd0, 4'd0}));
    for (int i = 1; i < 16; i++) begin
      feed(DW'(i));
      if (i == 14) check("t4_not_done_early", 32'(done), 32'd0);
    end
    check("t4_done", 32'(done), 32'd1);
    idle_tick();
    check("t4_writes", 32'(wa.size()), 32'd16);
    check("t4_w0", 32'({wa[0], wd[0]}), 32'({4'd0, 12'h7FF}));
    check("t4_w15", 32'(wa[15]), 32'd15);

    // Force ignored in FILL, then reset mid-POST
    force_trig = 1'b1;
    pulse_arm(4'd4);
    for (int i = 0; i < 3; i++) feed(12'd50);
    check("t5_force_in_fill", 32'({busy, armed}), 32'b10);
    feed(12'd50);
    check("t5_armed", 32'(armed), 32'd1);
    feed(12'd60);
    check("t5_trig", 32'({busy, armed, trig_addr, start_addr}), 32'({2'b10, 4'd4, 4'd0}));
    feed(12'd61);
    feed(12'd62);
    feed(12'd63);
    reset_n = 1'b0;
    sample  = 12'd77;
    tick();
    check("t5_rst_outs", 32'({ram_addr, ram_we, ram_din}), 32'd0);
    check("t5_rst_flags", 32'({busy, armed, done, trig_addr, start_addr}), 32'd0);
    n_before = wa.size();
    reset_n  = 1'b1;
    for (int i = 0; i < 5; i++) feed(DW'(i + 100));
    idle_tick();
    check("t5_no_writes", 32'(wa.size()), 32'(n_before));
    check("t5_idle", 32'({busy, armed, done}), 32'd0);

    // Re-arm mid-ARMED with the maximum pre of 15 (depth-1)
    force_trig  = 1'b0;
    trig_rising = 1'b1;
    trig_level  = 12'd100;
    pulse_arm(4'd2);
    for (int i = 0; i < 4; i++) feed(DW'(i));
    check("t6_armed_first", 32'(armed), 32'd1);
    sample_valid = 1'b1;
    sample       = 12'd55;
    pulse_arm(4'd15);
    check("t6_restart", 32'({busy, armed, done}), 32'b100);
    for (int i = 0; i < 15; i++) begin
      feed(12'd50);
      if (i == 13) check("t6_fill_14", 32'(armed), 32'd0);
      if (i == 14) check("t6_armed_15", 32'(armed), 32'd1);
    end
    force_trig = 1'b1;
    feed(12'd51);
    check("t6_done_direct", 32'({busy, armed, done}), 32'b001);
    check("t6_trig", 32'({trig_addr, start_addr}), 32'({4'd15, 4'd0}));
    idle_tick();
    check("t6_writes", 32'(wa.size()), 32'd16);
    check("t6_w0", 32'({wa[0], wd[0]}), 32'({4'd0, 12'd50}));
    check("t6_w15", 32'({wa[15], wd[15]}), 32'({4'd15, 12'd51}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
